// File: rtl/shade_axis_packer.sv
`default_nettype none
//============================================================================
// Module      : shade_axis_packer
// Description : Buffers shaded {R,G,B} pixels, substitutes the background
//               colour on misses and emits an AXI4-Stream video stream with
//               start-of-frame (tuser) and end-of-line (tlast) framing.
// Revision    : 1.0 - initial release
//============================================================================
module shade_axis_packer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [23:0] BG_COLOUR  = 24'h000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pixel_valid,
    input  logic                          pixel_hit,
    input  logic [23:0]                   pixel_rgb,
    output logic                          pixel_ready,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_x_w   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_y_w   = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_x_w-1:0]   c_x_last   = c_x_w'(H_RES - 1);
    localparam logic [c_y_w-1:0]   c_y_last   = c_y_w'(V_RES - 1);
    localparam logic [c_x_w-1:0]   c_x_one    = c_x_w'(1);
    localparam logic [c_y_w-1:0]   c_y_one    = c_y_w'(1);

    logic [23:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_x_w-1:0]    r_x;
    logic [c_y_w-1:0]    r_y;
    logic                r_frame_done;

    logic                w_push;
    logic                w_pop;
    logic                w_x_last;
    logic                w_y_last;

    // Ready depends only on the registered occupancy, so a pop in the same
    // cycle never frees a slot for a push while full.
    assign pixel_ready   = !rst && (r_count != c_full);
    assign m_axis_tvalid = (r_count != '0);

    assign w_push   = pixel_valid && pixel_ready;
    assign w_pop    = m_axis_tvalid && m_axis_tready;
    assign w_x_last = (r_x == c_x_last);
    assign w_y_last = (r_y == c_y_last);

    assign m_axis_tdata = m_axis_tvalid ? {8'h00, r_mem[r_rd_ptr]} : 32'h0;
    assign m_axis_tuser = m_axis_tvalid && (r_x == '0) && (r_y == '0);
    assign m_axis_tlast = m_axis_tvalid && w_x_last;
    assign frame_done   = r_frame_done;
    assign fill_level   = r_count;

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pixel_hit ? pixel_rgb : BG_COLOUR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Framing position advances once per accepted output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && w_x_last && w_y_last;
            if (w_pop) begin
                if (!w_x_last) begin
                    r_x <= r_x + c_x_one;
                end else begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + c_y_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shade_axis_packer.sv
`default_nettype none
//============================================================================
// Module      : tb_shade_axis_packer
// Description : Scoreboard bench for shade_axis_packer (H_RES=4, V_RES=2).
// Revision    : 1.0 - initial release
//============================================================================
module tb_shade_axis_packer;

    localparam int          c_h     = 4;
    localparam int          c_v     = 2;
    localparam int          c_depth = 4;
    localparam logic [23:0] c_bg    = 24'h0A0B0C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_valid = 1'b0;
    logic        pixel_hit = 1'b0;
    logic [23:0] pixel_rgb = 24'h0;
    logic        pixel_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        frame_done;
    logic [2:0]  fill_level;

    shade_axis_packer #(
        .H_RES      (c_h),
        .V_RES      (c_v),
        .FIFO_DEPTH (c_depth),
        .BG_COLOUR  (c_bg)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_valid   (pixel_valid),
        .pixel_hit     (pixel_hit),
        .pixel_rgb     (pixel_rgb),
        .pixel_ready   (pixel_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .fill_level    (fill_level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    int          occ_pre = 0;
    int          beat_idx = 0;
    logic        fd_exp = 1'b0;
    logic        model_live = 1'b0;
    int          dut_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: compares the DUT against the reference queue and
    // retires the head whenever a beat is handed off.
    always @(negedge clk) begin
        occ_pre = exp_q.size();
        if (model_live) begin
            check("fill_level", 32'(fill_level), 32'(occ_pre));
            check("tvalid", 32'(m_axis_tvalid), 32'(occ_pre != 0));
            check("pixel_ready", 32'(pixel_ready), 32'(!rst && occ_pre < c_depth));
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            if (occ_pre != 0) begin
                check("tdata", m_axis_tdata, {8'h00, exp_q[0]});
                check("tuser", 32'(m_axis_tuser), 32'(beat_idx == 0));
                check("tlast", 32'(m_axis_tlast), 32'((beat_idx % c_h) == c_h - 1));
            end else begin
                check("tdata_idle", m_axis_tdata, 32'h0);
                check("tuser_idle", 32'(m_axis_tuser), 32'h0);
                check("tlast_idle", 32'(m_axis_tlast), 32'h0);
            end
        end
        if (rst) begin
            exp_q.delete();
            beat_idx   = 0;
            fd_exp     = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            fd_exp = 1'b0;
            if (occ_pre != 0 && m_axis_tready) begin
                void'(exp_q.pop_front());
                fd_exp   = (beat_idx == c_h * c_v - 1);
                beat_idx = (beat_idx + 1) % (c_h * c_v);
            end
        end
    end

    // Input side of the scoreboard: every accepted pixel becomes an expected beat.
    always @(negedge clk) begin
        #1;
        if (!rst && pixel_valid && pixel_ready) dut_acc++;
        if (!rst && model_live && pixel_valid && occ_pre < c_depth) begin
            exp_q.push_back(pixel_hit ? pixel_rgb : c_bg);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic hit, input logic [23:0] rgb, input logic rdy);
        pixel_valid   = v;
        pixel_hit     = hit;
        pixel_rgb     = rgb;
        m_axis_tready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int acc0;
        step(3);
        rst = 1'b0;
        step(1);

        // Single hit pixel, then a miss that must come out as background.
        drive(1'b1, 1'b1, 24'hCCB380, 1'b1);
        step(1);
        drive(1'b1, 1'b0, 24'h123456, 1'b1);
        step(1);
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        step(3);

        // Backpressure: exactly four accepted while the sink stalls.
        acc0 = dut_acc;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'($urandom), 24'($urandom), 1'b0);
            step(1);
        end
        check("bp_accepted", 32'(dut_acc - acc0), 32'd4);
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        step(8);

        // Realign to frame start, then stream at full throughput.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 24'($urandom), 1'b1);
            step(1);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        step(3);

        // Random handshake toggling across several frames.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 24'($urandom),
                  1'($urandom_range(0, 2) != 0));
            step(1);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        step(6);

        // Mid-frame reset with five beats sent and two pixels buffered.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 24'($urandom), 1'b1);
            step(1);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        step(2);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 24'($urandom), 1'b0);
            step(1);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        check("pre_reset_fill", 32'(fill_level), 32'd2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'($urandom), 24'($urandom), 1'b1);
            step(1);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        step(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shade_axis_packer.md
Name: shade_axis_packer

Overview:
- Consumer end of the shader pixel interface: accepts 24-bit {R,G,B} shade pixels with valid/hit flags and emits an AXI4-Stream video stream.
- Sits between the ray-march/shading pipeline and the video DMA.
- Provides elastic buffering with backpressure to the shading pipeline.
- Substitutes the background colour on miss pixels and generates start-of-frame (tuser) and end-of-line (tlast) framing.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, lines per frame.
- FIFO_DEPTH, 4, pixel buffer entries; power of two, >= 2.
- BG_COLOUR, 24'h000000, {R,G,B} emitted when pixel_hit = 0.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- pixel_valid  in  1  shade pixel present.
- pixel_hit  in  1  ray hit; 0 selects BG_COLOUR.
- pixel_rgb  in  24  {R[23:16],G[15:8],B[7:0]} from shading.
- pixel_ready  out  1  block can accept a pixel this cycle.
- m_axis_tdata  out  32  {8'h00, R, G, B}.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts beat.
- m_axis_tuser  out  1  first pixel of frame (x=0, y=0).
- m_axis_tlast  out  1  last pixel of line (x=H_RES-1).
- frame_done  out  1  one-cycle pulse after the final beat of a frame.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clock edge): FIFO pointers, occupancy, and x/y counters go to 0. m_axis_tvalid, tuser, tlast, frame_done and tdata go to 0. pixel_ready = 0 while rst is high, 1 from the first cycle after rst deasserts. Reset mid-frame discards buffered pixels; the next output beat carries tuser=1.
- Push: pixel_valid && pixel_ready. Stores (pixel_hit ? pixel_rgb : BG_COLOUR) at the write pointer.
- Pop: m_axis_tvalid && m_axis_tready.
- pixel_ready = (occupancy != FIFO_DEPTH), registered from occupancy only. A push is not accepted while full, even if a pop occurs in the same cycle.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a pixel pushed at edge N is presented on m_axis_tdata with m_axis_tvalid=1 in the cycle after edge N (one cycle), provided it is at the FIFO head.
- m_axis_tvalid = (occupancy != 0). tdata shows the head entry, zero-extended; tdata = 0 when empty.
- AXI-Stream rules:
  - Once tvalid is high, tdata/tuser/tlast are held stable until the pop.
  - tvalid never drops without a pop.
  - tvalid does not depend combinationally on tready.
- Framing counters x (0..H_RES-1) and y (0..V_RES-1) advance only on pop:
  - x != H_RES-1: x+1.
  - x == H_RES-1: x=0, y+1.
  - x == H_RES-1 and y == V_RES-1: x=0, y=0, and frame_done pulses high for exactly one cycle following that pop edge.
- m_axis_tuser = tvalid && (x==0) && (y==0).
- m_axis_tlast = tvalid && (x==H_RES-1).
- Both framing flags are combinational from the counters and head-valid; no extra latency.
- Stall: tready=0 with a full FIFO holds pixel_ready=0 indefinitely. No data is lost or duplicated.
- Empty with pixel_valid and tready both high: the pixel is accepted and appears next cycle. There is no same-cycle bypass.
- fill_level equals occupancy after each edge.

Test Plan:
- Reset then a single pixel: push pixel_rgb=24'hCC_B3_80, hit=1, tready=1. Required: next cycle tdata=32'h00CCB380, tvalid=1, tuser=1, tlast=0. Following cycle tvalid=0 and fill_level=0.
- Miss substitution: push rgb=24'h123456 with hit=0 and BG_COLOUR=24'h0A0B0C. Required: tdata=32'h000A0B0C.
- Backpressure, FIFO_DEPTH=4: tready=0, pixel_valid=1 continuously. Required: exactly 4 pixels accepted, then pixel_ready=0 and fill_level=4. Raise tready: the 4 beats emerge in order with no duplicates, and pixel_ready returns to 1 the cycle after the first pop.
- Framing with H_RES=4, V_RES=2 and 8 streamed pixels at full throughput:
  - tuser only on beat 0.
  - tlast on beats 3 and 7.
  - frame_done high for one cycle after beat 7.
  - Beat 8 carries tuser=1 again.
- Random tvalid/tready toggling over 3 frames (H_RES=4, V_RES=2). Required:
  - Output sequence matches input sequence exactly.
  - tdata/tuser/tlast are stable whenever tvalid=1 and tready=0.
  - fill_level never exceeds 4.
- Mid-frame reset: assert rst after 5 beats with 2 pixels buffered. Required:
  - Next cycle tvalid=0 and fill_level=0.
  - pixel_ready=0 during rst.
  - The first post-reset beat has tuser=1 and frame_done does not pulse.
